// File: rtl/activation_mem_ctrl_pkg.sv
// rtl/activation_mem_ctrl_pkg.sv - shared types and sizes for the activation memory controller
package activation_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_ARR,
        ST_CAL,
        ST_DRAIN
    } state_e;

    localparam int ACT_DEPTH    = 64;
    localparam int ACT_W        = 7;
    localparam int COMP_PER_COL = 3;
    localparam int NUM_COLS     = 8;
    localparam int CAL_STEPS    = 9;

    localparam int ADDR_W = $clog2(ACT_DEPTH);
    localparam int CNT_W  = $clog2(ACT_DEPTH + 1);
    localparam int COL_W  = $clog2(NUM_COLS + 1);
    localparam int COMP_W = 3;

endpackage

// File: rtl/activation_mem_ctrl_comp_col_tracker.sv
// rtl/activation_mem_ctrl_comp_col_tracker.sv - per-column compensation counting, change_col timing and error flag
module comp_col_tracker
    import activation_mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic              comp_in_valid,
    input  logic [COMP_W-1:0] comp_row_in,
    input  logic              col_done,
    output logic              comp_out_valid,
    output logic [COMP_W-1:0] comp_row_out,
    output logic              change_col,
    output logic              err,
    output logic              all_cols_done,
    output logic              chg_pending
);

    logic [1:0]        cnt_q, cnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              pend_q, pend_d;
    logic              chg_q, chg_d;
    logic              cov_q, cov_d;
    logic [COMP_W-1:0] row_q, row_d;
    logic              err_q, err_d;
    logic              fwd, pulse, rel;
    logic [1:0]        n_eff;

    always_comb begin
        cnt_d  = cnt_q;
        col_d  = col_q;
        pend_d = pend_q;
        chg_d  = 1'b0;
        cov_d  = 1'b0;
        row_d  = row_q;
        err_d  = err_q;
        fwd    = 1'b0;
        pulse  = 1'b0;
        rel    = 1'b0;
        n_eff  = cnt_q;
        if (clear) begin
            cnt_d  = '0;
            col_d  = '0;
            pend_d = 1'b0;
            err_d  = 1'b0;
        end else if (enable) begin
            if (comp_in_valid) begin
                if (cnt_q == 2'(COMP_PER_COL)) begin
                    err_d = 1'b1;
                end else begin
                    fwd   = 1'b1;
                    cov_d = 1'b1;
                    row_d = comp_row_in;
                    cnt_d = cnt_q + 2'd1;
                end
            end
            // A same-cycle compensation counts toward this column before deciding on the pulse.
            n_eff = fwd ? cnt_q + 2'd1 : cnt_q;
            rel   = pend_q && !fwd;
            if (col_done) begin
                if (col_q == COL_W'(NUM_COLS)) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = '0;
                    col_d = col_q + 1'b1;
                    pulse = (n_eff == 2'd1) || (n_eff == 2'd2);
                end
            end
            // change_col is held back while a compensation is being forwarded so the two never overlap.
            chg_d  = rel || (pulse && !fwd);
            pend_d = (pend_q && !rel) || (pulse && fwd) || (rel && pulse && !fwd);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            col_q  <= '0;
            pend_q <= 1'b0;
            chg_q  <= 1'b0;
            cov_q  <= 1'b0;
            row_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            col_q  <= col_d;
            pend_q <= pend_d;
            chg_q  <= chg_d;
            cov_q  <= cov_d;
            row_q  <= row_d;
            err_q  <= err_d;
        end
    end

    assign comp_out_valid = cov_q;
    assign comp_row_out   = row_q;
    assign change_col     = chg_q;
    assign err            = err_q;
    assign all_cols_done  = (col_q == COL_W'(NUM_COLS));
    assign chg_pending    = pend_q;

endmodule

// File: rtl/activation_mem_ctrl.sv
// rtl/activation_mem_ctrl.sv - sequences activation load, compensation forwarding, array calculation and drain
module activation_mem_ctrl
    import activation_mem_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              act_in_valid,
    input  logic [ACT_W-1:0]  act_in,
    output logic              act_in_ready,
    input  logic              comp_in_valid,
    input  logic [COMP_W-1:0] comp_row_in,
    input  logic              col_done,
    input  logic              array_ready,
    output logic [ACT_W-1:0]  act_out,
    output logic [ADDR_W-1:0] act_addr,
    output logic              comp_out_valid,
    output logic [COMP_W-1:0] comp_row_out,
    output logic              change_col,
    output logic              load_mem_done,
    output logic              cal,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int STEP_W = 16;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  act_cnt_q, act_cnt_d;
    logic [ACT_W-1:0]  act_out_q, act_out_d;
    logic [ADDR_W-1:0] act_addr_q, act_addr_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              act_in_ready_q, act_in_ready_d;
    logic              load_mem_done_q, load_mem_done_d;
    logic              cal_q, cal_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs;
    logic              all_cols_done, chg_pending;

    comp_col_tracker u_tracker (
        .clk            (clk),
        .rst            (rst),
        .clear          ((state_q == ST_IDLE) && start),
        .enable         (state_q == ST_LOAD),
        .comp_in_valid  (comp_in_valid),
        .comp_row_in    (comp_row_in),
        .col_done       (col_done),
        .comp_out_valid (comp_out_valid),
        .comp_row_out   (comp_row_out),
        .change_col     (change_col),
        .err            (err),
        .all_cols_done  (all_cols_done),
        .chg_pending    (chg_pending)
    );

    always_comb begin
        state_d    = state_q;
        act_cnt_d  = act_cnt_q;
        act_out_d  = act_out_q;
        act_addr_d = act_addr_q;
        step_d     = step_q;
        done_d     = 1'b0;
        hs         = act_in_valid && act_in_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    act_cnt_d = '0;
                    step_d    = '0;
                end
            end
            ST_LOAD: begin
                // Outside a handshake the address/data pair is left untouched so repeated writes are harmless.
                if (hs) begin
                    act_out_d  = act_in;
                    act_addr_d = act_cnt_q[ADDR_W-1:0];
                    act_cnt_d  = act_cnt_q + 1'b1;
                end
                if (act_cnt_q == CNT_W'(ACT_DEPTH) && all_cols_done && !chg_pending) begin
                    state_d = ST_WAIT_ARR;
                end
            end
            ST_WAIT_ARR: begin
                if (array_ready) begin
                    state_d = ST_CAL;
                    step_d  = '0;
                end
            end
            ST_CAL: begin
                if (step_q == STEP_W'(CAL_STEPS - 1)) begin
                    state_d = ST_DRAIN;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (step_q == STEP_W'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        act_in_ready_d  = (state_d == ST_LOAD) && (act_cnt_d < CNT_W'(ACT_DEPTH));
        load_mem_done_d = (state_d != ST_LOAD);
        cal_d           = (state_d == ST_CAL);
        busy_d          = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            act_cnt_q       <= '0;
            act_out_q       <= '0;
            act_addr_q      <= '0;
            step_q          <= '0;
            act_in_ready_q  <= 1'b0;
            load_mem_done_q <= 1'b1;
            cal_q           <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            act_cnt_q       <= act_cnt_d;
            act_out_q       <= act_out_d;
            act_addr_q      <= act_addr_d;
            step_q          <= step_d;
            act_in_ready_q  <= act_in_ready_d;
            load_mem_done_q <= load_mem_done_d;
            cal_q           <= cal_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign act_in_ready  = act_in_ready_q;
    assign act_out       = act_out_q;
    assign act_addr      = act_addr_q;
    assign load_mem_done = load_mem_done_q;
    assign cal           = cal_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_activation_mem_ctrl.sv
// tb/tb_activation_mem_ctrl.sv - scoreboard bench for activation_mem_ctrl
module tb_activation_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       act_in_valid = 1'b0;
    logic [6:0] act_in = '0;
    logic       act_in_ready;
    logic       comp_in_valid = 1'b0;
    logic [2:0] comp_row_in = '0;
    logic       col_done = 1'b0;
    logic       array_ready = 1'b0;
    logic [6:0] act_out;
    logic [5:0] act_addr;
    logic       comp_out_valid;
    logic [2:0] comp_row_out;
    logic       change_col;
    logic       load_mem_done;
    logic       cal;
    logic       busy;
    logic       done;
    logic       err;

    activation_mem_ctrl #(.DRAIN_CYCLES(15)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .act_in_valid   (act_in_valid),
        .act_in         (act_in),
        .act_in_ready   (act_in_ready),
        .comp_in_valid  (comp_in_valid),
        .comp_row_in    (comp_row_in),
        .col_done       (col_done),
        .array_ready    (array_ready),
        .act_out        (act_out),
        .act_addr       (act_addr),
        .comp_out_valid (comp_out_valid),
        .comp_row_out   (comp_row_out),
        .change_col     (change_col),
        .load_mem_done  (load_mem_done),
        .cal            (cal),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int a;
        int b;
    } exp_t;

    exp_t exp_act[$];
    exp_t exp_comp[$];
    int   exp_chg[$];
    int   exp_done[$];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_addr = 0;
    bit   have_last = 0;
    exp_t last_pair;
    logic [6:0] stream [64];
    logic [6:0] mem [64];
    int   cal_len = 0;
    int   cal_fall = 0;
    bit   cal_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: compares DUT outputs against the queued expectations every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cal_prev = 0;
            cal_len  = 0;
        end else begin
            if (exp_act.size() > 0 && exp_act[0].cyc <= cyc) begin
                e = exp_act.pop_front();
                chk("act_time", cyc, e.cyc);
                chk("act_addr", act_addr, e.a);
                chk("act_out", act_out, e.b);
                last_pair = e;
                have_last = 1;
            end else if (!load_mem_done && busy && have_last) begin
                chk("hold_addr", act_addr, last_pair.a);
                chk("hold_data", act_out, last_pair.b);
            end
            if (!load_mem_done) mem[act_addr] = act_out;

            if (comp_out_valid) begin
                if (exp_comp.size() == 0) chk("comp_unexpected", comp_out_valid, 0);
                else begin
                    e = exp_comp.pop_front();
                    chk("comp_time", cyc, e.cyc);
                    chk("comp_row", comp_row_out, e.b);
                end
            end else if (exp_comp.size() > 0 && exp_comp[0].cyc < cyc) begin
                e = exp_comp.pop_front();
                chk("comp_missing", comp_out_valid, 1);
            end

            if (change_col) begin
                chk("chg_overlap_comp", comp_out_valid, 0);
                if (exp_chg.size() == 0) chk("chg_unexpected", change_col, 0);
                else chk("chg_time", cyc, exp_chg.pop_front());
            end else if (exp_chg.size() > 0 && exp_chg[0] < cyc) begin
                void'(exp_chg.pop_front());
                chk("chg_missing", change_col, 1);
            end

            if (cal) cal_len++;
            else if (cal_prev) begin
                chk("cal_len", cal_len, 9);
                cal_fall = cyc;
                cal_len  = 0;
            end
            cal_prev = cal;

            if (done) begin
                if (exp_done.size() == 0) chk("done_unexpected", done, 0);
                else begin
                    void'(exp_done.pop_front());
                    chk("done_delay", cyc - cal_fall, 15);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr  = 0;
        have_last = 0;
        chk("busy_after_start", busy, 1);
        chk("err_after_start", err, 0);
    endtask

    task automatic send_act(input logic [6:0] d);
        int t = 0;
        exp_t e;
        act_in_valid = 1'b1;
        act_in = d;
        while (!act_in_ready && t < 200) begin
            tick();
            t++;
        end
        if (!act_in_ready) chk("act_ready_timeout", act_in_ready, 1);
        else begin
            e.cyc = cyc + 1;
            e.a   = exp_addr;
            e.b   = d;
            exp_act.push_back(e);
            exp_addr++;
        end
        tick();
        act_in_valid = 1'b0;
    endtask

    task automatic comp(input logic [2:0] row, input bit fwd);
        exp_t e;
        comp_in_valid = 1'b1;
        comp_row_in   = row;
        if (fwd) begin
            e.cyc = cyc + 1;
            e.a   = 0;
            e.b   = row;
            exp_comp.push_back(e);
        end
        tick();
        comp_in_valid = 1'b0;
    endtask

    task automatic coldone(input bit chg);
        col_done = 1'b1;
        if (chg) exp_chg.push_back(cyc + 1);
        tick();
        col_done = 1'b0;
    endtask

    task automatic load_acts(input int mode);
        logic [6:0] d;
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0: d = 7'(i);
                1: d = 7'((i * 5 + 3) % 128);
                2: d = 7'((i * 9 + 1) % 128);
                default: d = 7'(63 - i);
            endcase
            stream[i] = d;
            send_act(d);
            if (mode == 1) tick();
        end
    endtask

    task automatic reach_wait_arr();
        int t = 0;
        while (!(busy && load_mem_done && !cal) && t < 100) begin
            tick();
            t++;
        end
        chk("reach_wait_arr", int'(busy && load_mem_done && !cal), 1);
        for (int i = 0; i < 64; i++) chk("mem_content", mem[i], stream[i]);
    endtask

    task automatic run_array(input bit expect_done);
        int t = 0;
        if (expect_done) exp_done.push_back(1);
        array_ready = 1'b1;
        tick();
        array_ready = 1'b0;
        while (busy && t < 100) begin
            tick();
            t++;
        end
        chk("job_idle", busy, 0);
    endtask

    initial begin
        int t;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_load_mem_done", load_mem_done, 1);
        chk("rst_cal", cal, 0);
        chk("rst_act_in_ready", act_in_ready, 0);
        chk("rst_act_out", act_out, 0);
        chk("rst_act_addr", act_addr, 0);
        chk("rst_comp_out_valid", comp_out_valid, 0);
        chk("rst_comp_row_out", comp_row_out, 0);
        chk("rst_change_col", change_col, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        // Job 1: plain load, no compensations.
        start_job();
        chk("load_mem_done_in_load", load_mem_done, 0);
        for (int c = 0; c < 8; c++) coldone(0);
        load_acts(0);
        reach_wait_arr();
        run_array(1);

        // Job 2: gapped stream, column 0 rows 2,5 and column 1 rows 1,3,7.
        start_job();
        comp(3'd2, 1);
        comp(3'd5, 1);
        coldone(1);
        comp(3'd1, 1);
        comp(3'd3, 1);
        comp(3'd7, 1);
        coldone(0);
        for (int c = 0; c < 6; c++) coldone(0);
        load_acts(1);
        reach_wait_arr();
        run_array(1);

        // Job 3: same-cycle comp and col_done, then an overfull column.
        start_job();
        begin
            exp_t e;
            comp_in_valid = 1'b1;
            comp_row_in   = 3'd4;
            col_done      = 1'b1;
            e.cyc = cyc + 1;
            e.a   = 0;
            e.b   = 4;
            exp_comp.push_back(e);
            exp_chg.push_back(cyc + 2);
            tick();
            comp_in_valid = 1'b0;
            col_done      = 1'b0;
            tick();
        end
        comp(3'd1, 1);
        comp(3'd2, 1);
        comp(3'd3, 1);
        chk("err_before_overflow", err, 0);
        comp(3'd6, 0);
        chk("err_after_overflow", err, 1);
        coldone(0);
        for (int c = 0; c < 6; c++) coldone(0);
        load_acts(2);
        reach_wait_arr();
        run_array(1);
        chk("err_sticky_idle", err, 1);

        // Job 4: reset in CAL cycle 4 aborts without done.
        start_job();
        for (int c = 0; c < 8; c++) coldone(0);
        load_acts(3);
        reach_wait_arr();
        array_ready = 1'b1;
        tick();
        array_ready = 1'b0;
        t = 0;
        while (!cal && t < 20) begin
            tick();
            t++;
        end
        chk("cal_rise", cal, 1);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("abort_cal", cal, 0);
        chk("abort_load_mem_done", load_mem_done, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_addr", act_addr, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();

        // Job 5: clean job after the abort, plus a surplus col_done.
        start_job();
        for (int c = 0; c < 8; c++) coldone(0);
        chk("err_before_extra_col", err, 0);
        coldone(0);
        chk("err_extra_col", err, 1);
        load_acts(1);
        reach_wait_arr();
        run_array(1);

        repeat (5) tick();
        chk("left_act", exp_act.size(), 0);
        chk("left_comp", exp_comp.size(), 0);
        chk("left_chg", exp_chg.size(), 0);
        chk("left_done", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/activation_mem_ctrl.md
ACTIVATION_MEM_CTRL -- requirements
Module: activation_mem_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 15; systolic-array drain latency after last Cal cycle.
REQ-002 SHALL have port clk  in  1  clock; reset rst, asynchronous, active-high.
REQ-003 SHALL have port start  in  1  single-cycle job request; accepted in IDLE only.
REQ-004 SHALL have ports act_in_valid in 1 and act_in in 7; activation stream, row-major, 64 values per job.
REQ-005 SHALL have port act_in_ready  out  1  high only in LOAD with fewer than 64 accepted.
REQ-006 SHALL have ports comp_in_valid in 1 and comp_row_in in 3; compensation row from the weight pre-load unit.
REQ-007 SHALL have port col_done  in  1  pulse; current weight column finished loading.
REQ-008 SHALL have port array_ready  in  1  systolic array idle and able to start.
REQ-009 SHALL have ports act_out out 7 and act_addr out 6; memory write data and address.
REQ-010 SHALL have ports comp_out_valid out 1, comp_row_out out 3, change_col out 1; memory compensation controls.
REQ-011 SHALL have ports load_mem_done out 1 and cal out 1; memory phase controls.
REQ-012 SHALL have ports busy out 1, done out 1 (one-cycle pulse), err out 1 (sticky until next start).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, WAIT_ARR, CAL, DRAIN.
REQ-014 IDLE: load_mem_done=1, cal=0, busy=0; start -> LOAD, clears counters and err.
REQ-015 LOAD: load_mem_done=0; each act_in_valid&&act_in_ready handshake registers act_in/act_addr; act_addr starts at 0 and increments by 1.
REQ-016 When no handshake occurs, act_out/act_addr SHALL hold the last accepted pair, so the memory's every-cycle write is idempotent.
REQ-017 comp_in_valid SHALL be registered to comp_out_valid/comp_row_out with 1-cycle latency.
REQ-018 A per-column counter (0..3) SHALL count forwarded compensations; a 4th compensation in one column SHALL be dropped and set err.
REQ-019 col_done SHALL produce a one-cycle change_col pulse only when the column counter is 1 or 2; a count of 0 or 3 SHALL produce no pulse. In both cases the column counter SHALL clear and the column index SHALL increment.
REQ-020 comp_in_valid and col_done in the same cycle: the compensation SHALL be forwarded first; change_col SHALL be issued in the following cycle and SHALL never coincide with comp_out_valid.
REQ-021 LOAD -> WAIT_ARR SHALL occur when 64 activations have been accepted, 8 col_done pulses have been seen, and no change_col is pending.
REQ-022 col_done beyond the 8th SHALL be ignored and set err.
REQ-023 WAIT_ARR: load_mem_done=1, cal=0; array_ready -> CAL.
REQ-024 CAL: load_mem_done=1, cal=1 for exactly 9 cycles, covering memory index 0..8, then -> DRAIN.
REQ-025 DRAIN: cal=0 for DRAIN_CYCLES cycles; on the last cycle assert done for 1 cycle and go to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 On rst the FSM SHALL enter IDLE and all counters SHALL clear.
REQ-029 Reset values SHALL be: load_mem_done=1, cal=0, act_in_ready=0, act_out=0, act_addr=0, comp_out_valid=0, comp_row_out=0, change_col=0, busy=0, done=0, err=0.
REQ-030 rst asserted mid-job SHALL abort the job without a done pulse; the next start SHALL begin a clean job at address 0.

Structure
REQ-031 Shared package SHALL hold: the state enum; ACT_DEPTH=64, ACT_W=7, COMP_PER_COL=3, NUM_COLS=8, CAL_STEPS=9.
REQ-032 Sub-module comp_col_tracker SHALL own the per-column counter, column index, deferred change_col and err generation.

Verification
REQ-033 Scenario: start, 64 back-to-back activations 0..63, 8 col_done with no comps, array_ready -> act_addr 0..63, no change_col, cal high 9 cycles, done 15 cycles after cal falls.
REQ-034 Scenario: act_in_valid toggling 1/0 -> act_addr/act_out hold during idle gaps; memory contents equal the stream.
REQ-035 Scenario: column 0 gets rows 2,5 then col_done; column 1 gets rows 1,3,7 then col_done -> comp_out_valid x5; change_col only after column 0.
REQ-036 Scenario: comp_in_valid (row 4) and col_done in the same cycle -> comp_out_valid at T+1, change_col at T+2.
REQ-037 Scenario: 4 comps in one column -> 3 forwarded, err=1; err clears on the next start.
REQ-038 Scenario: rst during CAL cycle 4 -> cal=0, load_mem_done=1, no done; the next job completes normally.
